imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: receives a program image as a byte stream
//  (valid/ready), packs little-endian bytes into 32-bit words and drives the imem write port.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } imem_ldr_state_t;

    localparam int IMEM_WORD_BYTES  = 4;
    localparam int IMEM_DEPTH_WORDS = 256;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 packer: the first byte of each group of four lands in
// bits [7:0]. word_vld pulses combinationally with the fourth byte so the
// caller can register the completed word in the following cycle.
import imem_loader_pkg::*;

module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_vld
);

    localparam int CNT_W = $clog2(IMEM_WORD_BYTES);

    logic [CNT_W-1:0] cnt_q;
    logic [23:0]      sr_q;

    assign word     = {byte_in, sr_q};
    assign word_vld = byte_vld && (cnt_q == CNT_W'(IMEM_WORD_BYTES - 1));

    // Byte position within the current word; reset/clear discards a partial word.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt_q <= '0;
        else if (byte_vld)
            cnt_q <= cnt_q + 1'b1;
    end

    // Shift earlier bytes down so the newest byte ends up highest.
    always_ff @(posedge clk) begin
        if (byte_vld)
            sr_q <= {byte_in, sr_q[23:8]};
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory. Reads a 4-byte LE
// word count, then that many LE data words, writing each to imem at
// word_idx<<2 while holding the core. Optional macro IMEM_LOADER_CHECKSUM_EN
// adds a 4-byte LE trailer compared against the mod-2^32 sum of data words.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int DEPTH  = IMEM_DEPTH_WORDS,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    imem_ldr_state_t state_q, state_d;

    logic        acc;
    logic        wvld;
    logic [31:0] word;
    logic [31:0] n_q;
    logic [31:0] widx_q;
    logic        clr, ld_n, we_d, set_done, set_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    // Ready depends on state only, never on s_valid.
    assign s_ready   = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign busy      = s_ready;
    assign core_hold = busy;
    assign acc       = s_valid && s_ready;

    imem_loader_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clr),
        .byte_vld (acc),
        .byte_in  (s_data),
        .word     (word),
        .word_vld (wvld)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        ld_n     = 1'b0;
        we_d     = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN;
                    clr     = 1'b1;
                end
            end
            LEN: begin
                if (wvld) begin
                    ld_n = 1'b1;
                    if (word == 32'd0) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end else if (word > 32'(DEPTH)) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                        set_err  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (wvld) begin
                    we_d = 1'b1;
                    if (widx_q == n_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d  = DONE;
                        set_done = 1'b1;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (wvld) begin
                    state_d  = DONE;
                    set_done = 1'b1;
                    set_err  = (word != sum_q);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered write port, counters and sticky status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q       <= '0;
            widx_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= we_d;
            if (clr) begin
                n_q    <= '0;
                widx_q <= '0;
                done   <= 1'b0;
                err    <= 1'b0;
            end
            if (ld_n)
                n_q <= word;
            if (we_d) begin
                mem_addr  <= ADDR_W'(widx_q << 2);
                mem_wdata <= word;
                widx_q    <= widx_q + 32'd1;
            end
            if (set_done)
                done <= 1'b1;
            if (set_err)
                err <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running mod-2^32 sum of written data words for the trailer compare.
    always_ff @(posedge clk) begin
        if (clr)
            sum_q <= '0;
        else if (we_d)
            sum_q <= sum_q + word;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_hold;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    // Every write must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [63:0] e;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_we observed addr=%h data=%h expected no write", mem_addr, mem_wdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({mem_addr, mem_wdata} === e) else begin
                    bad++;
                    $error("FAIL write observed=%h_%h expected=%h_%h", mem_addr, mem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_data(input logic [31:0] w, input logic [31:0] addr, input int gap);
        exp_q.push_back({addr, w});
        send_word(w, gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic settle_idle();
        for (int i = 0; i < 2; i++) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_we", mem_we, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two-word image, back-to-back bytes
        pulse_start();
        check("t1_hold", core_hold, 1'b1);
        send_word(32'd2, 0);
        send_data(32'h00000513, 32'h0, 0);
        check("t1_hold_mid", core_hold, 1'b1);
        send_data(32'h07B00593, 32'h4, 0);
        check("t1_done", done, 1'b1);
        check("t1_err", err, 1'b0);
        @(negedge clk);
        check("t1_hold_after", core_hold, 1'b0);
        settle_idle();

        // 2: N=0, then start during the DONE cycle must be ignored
        pulse_start();
        check("t2_done_cleared", done, 1'b0);
        send_word(32'd0, 0);
        check("t2_done_next", done, 1'b1);
        check("t2_err", err, 1'b0);
        pulse_start();
        check("t2_start_in_done_ignored", s_ready, 1'b0);
        check("t2_done_kept", done, 1'b1);
        settle_idle();

        // 3: N=257 rejected, trailing bytes not consumed
        pulse_start();
        send_word(32'd257, 0);
        wait_done();
        check("t3_err", err, 1'b1);
        s_valid = 1'b1; s_data = 8'h13;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_not_consumed", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        settle_idle();

        // 4: same image with 3-cycle gaps and a stray start mid-load
        pulse_start();
        check("t4_err_cleared", err, 1'b0);
        send_word(32'd2, 3);
        send_data(32'h00000513, 32'h0, 3);
        pulse_start();
        check("t4_busy_after_start", busy, 1'b1);
        send_data(32'h07B00593, 32'h4, 3);
        check("t4_done", done, 1'b1);
        check("t4_err", err, 1'b0);
        settle_idle();

        // 5: reset after 6 bytes, then clean reload
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_err", err, 1'b0);
        check("t5_we", mem_we, 1'b0);
        check("t5_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        send_word(32'd2, 0);
        send_data(32'h00000513, 32'h0, 0);
        send_data(32'h07B00593, 32'h4, 0);
        check("t5_reload_done", done, 1'b1);
        check("t5_reload_err", err, 1'b0);
        settle_idle();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: trailer good, then trailer bad
        pulse_start();
        send_word(32'd2, 0);
        send_data(32'h00000513, 32'h0, 0);
        send_data(32'h07B00593, 32'h4, 0);
        check("t6_busy_in_csum", busy, 1'b1);
        send_word(32'h07B00AA6, 0);
        wait_done();
        check("t6_good_err", err, 1'b0);
        settle_idle();
        pulse_start();
        send_word(32'd2, 0);
        send_data(32'h00000513, 32'h0, 0);
        send_data(32'h07B00593, 32'h4, 0);
        send_word(32'h00000000, 0);
        wait_done();
        check("t6_bad_err", err, 1'b1);
        settle_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
